// File: rtl/pipe_interlock_pkg.sv
// Shared opcode definitions, instruction field positions and decode helpers.
package pipe_interlock_pkg;

  localparam int unsigned IR_W      = 16;
  localparam int unsigned OPC_LSB   = 0;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned IMM_BIT   = 4;
  localparam int unsigned RX_LSB    = 5;
  localparam int unsigned RY_LSB    = 8;
  localparam int unsigned REG_IDX_W = 3;

  localparam logic [OPC_W-1:0] OP_MV   = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPC_W-1:0] OP_CMP  = 4'd3;
  localparam logic [OPC_W-1:0] OP_LD   = 4'd4;
  localparam logic [OPC_W-1:0] OP_ST   = 4'd5;
  localparam logic [OPC_W-1:0] OP_MVHI = 4'd6;
  localparam logic [OPC_W-1:0] OP_J    = 4'd7;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'd8;
  localparam logic [OPC_W-1:0] OP_JN   = 4'd9;
  localparam logic [OPC_W-1:0] OP_CALL = 4'd10;
  localparam logic [OPC_W-1:0] OP_NOP  = 4'd15;

  localparam logic [REG_IDX_W-1:0] LINK_REG = 3'd7;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH2
  } state_e;

  function automatic logic [OPC_W-1:0] opc(input logic [IR_W-1:0] ir);
    return ir[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic is_imm(input logic [IR_W-1:0] ir);
    return ir[IMM_BIT];
  endfunction

  function automatic logic [REG_IDX_W-1:0] rx(input logic [IR_W-1:0] ir);
    return ir[RX_LSB +: REG_IDX_W];
  endfunction

  function automatic logic [REG_IDX_W-1:0] ry(input logic [IR_W-1:0] ir);
    return ir[RY_LSB +: REG_IDX_W];
  endfunction

  function automatic logic is_writer(input logic [IR_W-1:0] ir);
    logic w;
    w = 1'b0;
    case (opc(ir))
      OP_MV, OP_ADD, OP_SUB, OP_LD, OP_MVHI, OP_CALL: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // CALL always links into R7 regardless of the Rx field.
  function automatic logic [REG_IDX_W-1:0] dest_reg(input logic [IR_W-1:0] ir);
    return (opc(ir) == OP_CALL) ? LINK_REG : rx(ir);
  endfunction

  function automatic logic reads_rx(input logic [IR_W-1:0] ir);
    logic r;
    r = 1'b0;
    case (opc(ir))
      OP_ADD, OP_SUB, OP_CMP, OP_ST, OP_MVHI: r = 1'b1;
      OP_J, OP_JZ, OP_JN, OP_CALL:            r = !is_imm(ir);
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reads_ry(input logic [IR_W-1:0] ir);
    logic r;
    r = 1'b0;
    case (opc(ir))
      OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST: r = !is_imm(ir);
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_interlock_reg_scoreboard.sv
// Per-register saturating count of in-flight writers with sticky error flag.
module pipe_interlock_reg_scoreboard
  import pipe_interlock_pkg::*;
#(
  parameter int unsigned NREG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic [REG_IDX_W-1:0] inc_idx,
  input  logic                 dec_en,
  input  logic [REG_IDX_W-1:0] dec_idx,
  output logic [NREG-1:0]      o_pending,
  output logic                 o_sb_err
);

  logic [1:0]      cnt_q [NREG];
  logic [1:0]      cnt_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic            err_q, err_d;

  // Next counts; simultaneous inc and dec of one register cancel out.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_en && (inc_idx == REG_IDX_W'(r)) && !(dec_en && (dec_idx == REG_IDX_W'(r)))) begin
        if (cnt_q[r] == 2'd3) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (dec_en && (dec_idx == REG_IDX_W'(r)) && !(inc_en && (inc_idx == REG_IDX_W'(r)))) begin
        if (cnt_q[r] == 2'd0) err_d = 1'b1;
        else                  cnt_d[r] = cnt_q[r] - 2'd1;
      end
      pending_d[r] = (cnt_d[r] != 2'd0);
    end
  end

  // Counter, pending and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign o_pending = pending_q;
  assign o_sb_err  = err_q;

endmodule

// File: rtl/pipe_interlock.sv
// Pipeline interlock: load-use stall, taken-branch flush, memory-wait freeze.
module pipe_interlock
  import pipe_interlock_pkg::*;
#(
  parameter int unsigned NREG  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rf_valid,
  input  logic [IR_W-1:0]  i_rf_ir,
  input  logic             i_ex_valid,
  input  logic [IR_W-1:0]  i_ex_ir,
  input  logic             i_wb_valid,
  input  logic [IR_W-1:0]  i_wb_ir,
  input  logic             i_br_taken,
  input  logic             i_mem_wait,
  output logic             o_stall_pc,
  output logic             o_stall_rf,
  output logic             o_bubble_ex,
  output logic             o_flush,
  output logic [NREG-1:0]  o_pending,
  output logic             o_sb_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic                    load_use_c, flush_c, stall_c, bubble_c;
  logic                    inc_en, dec_en;
  logic [REG_IDX_W-1:0]    inc_idx, dec_idx;

  // Hazard detection, control outputs, FSM and counter next-state.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_c     = 1'b0;
    stall_c     = 1'b0;
    bubble_c    = 1'b0;
    inc_en      = 1'b0;
    dec_en      = 1'b0;
    inc_idx     = dest_reg(i_rf_ir);
    dec_idx     = dest_reg(i_wb_ir);

    load_use_c = i_rf_valid && i_ex_valid && (opc(i_ex_ir) == OP_LD) &&
                 ((reads_rx(i_rf_ir) && (rx(i_rf_ir) == rx(i_ex_ir))) ||
                  (reads_ry(i_rf_ir) && (ry(i_rf_ir) == rx(i_ex_ir))));

    if (!rst) begin
      flush_c = i_br_taken || (state_q == ST_FLUSH2);
      if (i_mem_wait) begin
        stall_c = 1'b1;
      end else if (!flush_c && load_use_c) begin
        stall_c     = 1'b1;
        bubble_c    = 1'b1;
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      // A waiting cycle freezes the FSM; otherwise each taken branch (re)arms FLUSH2.
      if (!i_mem_wait) begin
        if (i_br_taken) begin
          state_d     = ST_FLUSH2;
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      inc_en = i_rf_valid && is_writer(i_rf_ir) && !stall_c && !flush_c && !i_mem_wait;
      dec_en = i_wb_valid && is_writer(i_wb_ir) && !i_mem_wait;
    end
  end

  // FSM and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  pipe_interlock_reg_scoreboard #(
    .NREG (NREG)
  ) u_reg_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (inc_en),
    .inc_idx   (inc_idx),
    .dec_en    (dec_en),
    .dec_idx   (dec_idx),
    .o_pending (o_pending),
    .o_sb_err  (o_sb_err)
  );

  assign o_stall_pc  = stall_c;
  assign o_stall_rf  = stall_c;
  assign o_bubble_ex = bubble_c;
  assign o_flush     = flush_c;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_interlock.sv
// Directed scoreboard bench: stimulus queues expected outputs, monitor compares each cycle.
module tb_pipe_interlock;
  import pipe_interlock_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rf_v = 1'b0, ex_v = 1'b0, wb_v = 1'b0, br = 1'b0, mw = 1'b0;
  logic [15:0] rf_ir, ex_ir, wb_ir;
  logic        stall_pc, stall_rf, bubble_ex, flush, sb_err;
  logic [7:0]  pending;
  logic [15:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic        spc;
    logic        srf;
    logic        bub;
    logic        fl;
    logic [7:0]  pend;
    logic        err;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } outv_t;

  outv_t exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pipe_interlock #(.NREG(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rf_valid  (rf_v),
    .i_rf_ir     (rf_ir),
    .i_ex_valid  (ex_v),
    .i_ex_ir     (ex_ir),
    .i_wb_valid  (wb_v),
    .i_wb_ir     (wb_ir),
    .i_br_taken  (br),
    .i_mem_wait  (mw),
    .o_stall_pc  (stall_pc),
    .o_stall_rf  (stall_rf),
    .o_bubble_ex (bubble_ex),
    .o_flush     (flush),
    .o_pending   (pending),
    .o_sb_err    (sb_err),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );

  function automatic logic [15:0] mk(input logic [3:0] op, input logic imm,
                                     input logic [2:0] x, input logic [2:0] y);
    return {5'b0, y, x, imm, op};
  endfunction

  function automatic outv_t ev(input logic spc, input logic srf, input logic bub,
                               input logic fl, input logic [7:0] pend, input logic err,
                               input int scnt, input int fcnt);
    outv_t e;
    e.spc = spc; e.srf = srf; e.bub = bub; e.fl = fl;
    e.pend = pend; e.err = err; e.scnt = 16'(scnt); e.fcnt = 16'(fcnt);
    return e;
  endfunction

  // Advance to the next cycle and return all inputs to idle.
  task automatic next_cyc();
    @(posedge clk);
    #1;
    rst = 1'b0; rf_v = 1'b0; ex_v = 1'b0; wb_v = 1'b0; br = 1'b0; mw = 1'b0;
    rf_ir = mk(OP_NOP, 1'b0, 3'd0, 3'd0);
    ex_ir = rf_ir;
    wb_ir = rf_ir;
  endtask

  task automatic expect_out(input string nm, input outv_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one comparison per queued cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outv_t e, g;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {stall_pc, stall_rf, bubble_ex, flush, pending, sb_err, stall_cnt, flush_cnt};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got spc=%b srf=%b bub=%b fl=%b pend=%h err=%b scnt=%0d fcnt=%0d, required spc=%b srf=%b bub=%b fl=%b pend=%h err=%b scnt=%0d fcnt=%0d",
                 nm, g.spc, g.srf, g.bub, g.fl, g.pend, g.err, g.scnt, g.fcnt,
                 e.spc, e.srf, e.bub, e.fl, e.pend, e.err, e.scnt, e.fcnt);
      end
    end
  end

  initial begin
    logic [15:0] add_r2_r1, add_r2_i, ld_r1, mv_r3, add_r3_r3, call_i, mv_r4, mv_r5;
    add_r2_r1 = mk(OP_ADD,  1'b0, 3'd2, 3'd1);
    add_r2_i  = mk(OP_ADD,  1'b1, 3'd2, 3'd1);
    ld_r1     = mk(OP_LD,   1'b1, 3'd1, 3'd0);
    mv_r3     = mk(OP_MV,   1'b1, 3'd3, 3'd0);
    add_r3_r3 = mk(OP_ADD,  1'b0, 3'd3, 3'd3);
    call_i    = mk(OP_CALL, 1'b1, 3'd0, 3'd0);
    mv_r4     = mk(OP_MV,   1'b1, 3'd4, 3'd0);
    mv_r5     = mk(OP_MV,   1'b1, 3'd5, 3'd0);
    rf_ir = 16'hF; ex_ir = 16'hF; wb_ir = 16'hF;

    next_cyc(); rst = 1'b1;                 expect_out("reset",       ev(0,0,0,0,8'h00,0,0,0));
    next_cyc();                             expect_out("idle",        ev(0,0,0,0,8'h00,0,0,0));
    // Load-use: ADD R2,R1 behind LD R1.
    next_cyc(); rf_v=1; rf_ir=add_r2_r1; ex_v=1; ex_ir=ld_r1;
                                            expect_out("lu_stall",    ev(1,1,1,0,8'h00,0,0,0));
    next_cyc(); rf_v=1; rf_ir=add_r2_r1;    expect_out("lu_release",  ev(0,0,0,0,8'h00,0,1,0));
    next_cyc(); wb_v=1; wb_ir=add_r2_r1;    expect_out("r2_pending",  ev(0,0,0,0,8'h04,0,1,0));
    // Immediate form does not read Ry.
    next_cyc(); rf_v=1; rf_ir=add_r2_i; ex_v=1; ex_ir=ld_r1;
                                            expect_out("imm_nostall", ev(0,0,0,0,8'h00,0,1,0));
    next_cyc(); wb_v=1; wb_ir=add_r2_i;     expect_out("imm_retire",  ev(0,0,0,0,8'h04,0,1,0));
    // Taken branch over a load-use pair.
    next_cyc(); br=1; rf_v=1; rf_ir=add_r2_r1; ex_v=1; ex_ir=ld_r1;
                                            expect_out("br_flush1",   ev(0,0,0,1,8'h00,0,1,0));
    next_cyc(); rf_v=1; rf_ir=add_r2_r1; ex_v=1; ex_ir=ld_r1;
                                            expect_out("br_flush2",   ev(0,0,0,1,8'h00,0,1,1));
    next_cyc();                             expect_out("br_done",     ev(0,0,0,0,8'h00,0,1,1));
    // Memory wait over a load-use hazard.
    for (int i = 0; i < 3; i++) begin
      next_cyc(); mw=1; rf_v=1; rf_ir=add_r2_r1; ex_v=1; ex_ir=ld_r1;
                                            expect_out("mw_freeze",   ev(1,1,0,0,8'h00,0,1,1));
    end
    next_cyc(); rf_v=1; rf_ir=add_r2_r1; ex_v=1; ex_ir=ld_r1;
                                            expect_out("mw_lu_stall", ev(1,1,1,0,8'h00,0,1,1));
    next_cyc(); rf_v=1; rf_ir=add_r2_r1;    expect_out("mw_release",  ev(0,0,0,0,8'h00,0,2,1));
    next_cyc(); wb_v=1; wb_ir=add_r2_r1;    expect_out("mw_r2_pend",  ev(0,0,0,0,8'h04,0,2,1));
    // Back-to-back writers of R3, then CALL.
    next_cyc(); rf_v=1; rf_ir=mv_r3;        expect_out("mv_r3_issue", ev(0,0,0,0,8'h00,0,2,1));
    next_cyc(); rf_v=1; rf_ir=add_r3_r3; ex_v=1; ex_ir=mv_r3;
                                            expect_out("r3_cnt1",     ev(0,0,0,0,8'h08,0,2,1));
    next_cyc(); wb_v=1; wb_ir=mv_r3;        expect_out("r3_cnt2",     ev(0,0,0,0,8'h08,0,2,1));
    next_cyc(); wb_v=1; wb_ir=add_r3_r3;    expect_out("r3_cnt1b",    ev(0,0,0,0,8'h08,0,2,1));
    next_cyc(); rf_v=1; rf_ir=call_i;       expect_out("r3_clear",    ev(0,0,0,0,8'h00,0,2,1));
    next_cyc();                             expect_out("call_r7",     ev(0,0,0,0,8'h80,0,2,1));
    next_cyc(); wb_v=1; wb_ir=call_i;       expect_out("call_hold",   ev(0,0,0,0,8'h80,0,2,1));
    // Same-cycle inc and dec of R4 at count 0: no change, no error.
    next_cyc(); rf_v=1; rf_ir=mv_r4; wb_v=1; wb_ir=mv_r4;
                                            expect_out("r7_clear",    ev(0,0,0,0,8'h00,0,2,1));
    next_cyc();                             expect_out("r4_net_zero", ev(0,0,0,0,8'h00,0,2,1));
    // Underflow of R5.
    next_cyc(); wb_v=1; wb_ir=mv_r5;        expect_out("pre_underflow", ev(0,0,0,0,8'h00,0,2,1));
    next_cyc();                             expect_out("sb_err_set",  ev(0,0,0,0,8'h00,1,2,1));
    next_cyc();                             expect_out("sb_err_stick",ev(0,0,0,0,8'h00,1,2,1));
    // Memory wait inside FLUSH2 holds the flush.
    next_cyc(); br=1;                       expect_out("br2_flush1",  ev(0,0,0,1,8'h00,1,2,1));
    next_cyc(); mw=1;                       expect_out("br2_mw_hold", ev(1,1,0,1,8'h00,1,2,2));
    next_cyc();                             expect_out("br2_flush2",  ev(0,0,0,1,8'h00,1,2,2));
    next_cyc();                             expect_out("br2_done",    ev(0,0,0,0,8'h00,1,2,2));
    // Reset in FLUSH2: no further flush cycle.
    next_cyc(); br=1;                       expect_out("br3_flush1",  ev(0,0,0,1,8'h00,1,2,2));
    next_cyc(); rst=1;                      expect_out("rst_mid",     ev(0,0,0,0,8'h00,1,2,3));
    next_cyc();                             expect_out("post_rst",    ev(0,0,0,0,8'h00,0,0,0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
